// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) arithmetic: field ops, affine maps, forward/inverse S-box, rcon.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and naturally yields 0 for a == 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] y);
    return rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return affine(gf_inv(x));
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(inv_affine(y));
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box; one instance per byte lane of InvSubBytes.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] b
);

  assign b = inv_sbox(a);

endmodule

// File: rtl/aes_key_expand_inv_sbox.sv
// AES-128 key expander (one round key per clock after kld) plus a standalone
// combinational inverse S-box lookup for the decryptor datapath.
module aes_key_expand_inv_sbox
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3,
  input  logic [7:0]   sbox_in,
  output logic [7:0]   sbox_out
);

  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [31:0] rot_w;
  logic [31:0] t_w;

  assign rot_w = {w3_q[23:0], w3_q[31:24]};
  assign t_w   = {sbox(rot_w[31:24]) ^ RCON[rnd_q],
                  sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),
                  sbox(rot_w[7:0])};

  always_comb begin
    w0_d  = w0_q;
    w1_d  = w1_q;
    w2_d  = w2_q;
    w3_d  = w3_q;
    rnd_d = rnd_q;
    if (kld) begin
      {w0_d, w1_d, w2_d, w3_d} = key;
      rnd_d = 4'd0;
    end else if (rnd_q < 4'(NUM_ROUNDS)) begin
      // Each word chains off the freshly computed previous word.
      w0_d  = w0_q ^ t_w;
      w1_d  = w0_d ^ w1_q;
      w2_d  = w1_d ^ w2_q;
      w3_d  = w2_d ^ w3_q;
      rnd_d = rnd_q + 4'd1;
    end
  end

  // Reset parks the expander in the idle (round 10) hold state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0_q  <= '0;
      w1_q  <= '0;
      w2_q  <= '0;
      w3_q  <= '0;
      rnd_q <= 4'(NUM_ROUNDS);
    end else begin
      w0_q  <= w0_d;
      w1_q  <= w1_d;
      w2_q  <= w2_d;
      w3_q  <= w3_d;
      rnd_q <= rnd_d;
    end
  end

  assign wo_0 = w0_q;
  assign wo_1 = w1_q;
  assign wo_2 = w2_q;
  assign wo_3 = w3_q;

  aes_inv_sbox u_inv_sbox (
    .a (sbox_in),
    .b (sbox_out)
  );

endmodule

// File: tb/tb_aes_key_expand_inv_sbox.sv
// Directed bench for the AES-128 key expander and inverse S-box lookup.
module tb_aes_key_expand_inv_sbox;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic [31:0]  wo_0, wo_1, wo_2, wo_3;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  logic [7:0] fwd_tbl [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  aes_key_expand_inv_sbox dut (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld),
    .key      (key),
    .wo_0     (wo_0),
    .wo_1     (wo_1),
    .wo_2     (wo_2),
    .wo_3     (wo_3),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    tick();
    kld = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] got;
    rst = 1'b0;
    kld = 1'b0;
    key = '0;
    sbox_in = 8'h00;
    tick();
    tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, 128'h0);
    end
    rst = 1'b1;
    tick();
    load_key(FIPS_KEY);
    tick();
    tick();
    // Asynchronous assertion mid-cycle, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", got, 128'h0);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", got, 128'h0);
    end
  endtask

  task automatic test_fips_key();
    logic [127:0] got;
    load_key(FIPS_KEY);
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== FIPS_KEY) begin
      errors++;
      $display("FAIL fips_r0 got=%h exp=%h", got, FIPS_KEY);
    end
    tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== FIPS_R1) begin
      errors++;
      $display("FAIL fips_r1 got=%h exp=%h", got, FIPS_R1);
    end
    for (int i = 2; i <= 10; i++) tick();
    for (int i = 0; i <= 5; i++) begin
      got = {wo_0, wo_1, wo_2, wo_3};
      checks++;
      if (got !== FIPS_R10) begin
        errors++;
        $display("FAIL fips_r10_hold%0d got=%h exp=%h", i, got, FIPS_R10);
      end
      tick();
    end
  endtask

  task automatic test_zero_key();
    logic [127:0] got;
    load_key(128'h0);
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL zero_r0 got=%h exp=%h", got, 128'h0);
    end
    tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== ZERO_R1) begin
      errors++;
      $display("FAIL zero_r1 got=%h exp=%h", got, ZERO_R1);
    end
    tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== ZERO_R2) begin
      errors++;
      $display("FAIL zero_r2 got=%h exp=%h", got, ZERO_R2);
    end
  endtask

  task automatic test_restart();
    logic [127:0] got;
    load_key(FIPS_KEY);
    tick();
    tick();
    tick();
    load_key(128'h0);
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL restart_r0 got=%h exp=%h", got, 128'h0);
    end
    tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== ZERO_R1) begin
      errors++;
      $display("FAIL restart_r1 got=%h exp=%h", got, ZERO_R1);
    end
    tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== ZERO_R2) begin
      errors++;
      $display("FAIL restart_r2 got=%h exp=%h", got, ZERO_R2);
    end
  endtask

  task automatic test_kld_held();
    logic [127:0] got;
    kld = 1'b1;
    key = FIPS_KEY;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {wo_0, wo_1, wo_2, wo_3};
      checks++;
      if (got !== FIPS_KEY) begin
        errors++;
        $display("FAIL kld_held%0d got=%h exp=%h", i, got, FIPS_KEY);
      end
    end
    kld = 1'b0;
    tick();
    got = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if (got !== FIPS_R1) begin
      errors++;
      $display("FAIL kld_release_r1 got=%h exp=%h", got, FIPS_R1);
    end
  endtask

  task automatic test_inv_sbox_spot();
    logic [7:0] ins  [5] = '{8'h00, 8'h01, 8'h0f, 8'h63, 8'hff};
    logic [7:0] exps [5] = '{8'h52, 8'h09, 8'hfb, 8'h00, 8'h7d};
    for (int i = 0; i < 5; i++) begin
      sbox_in = ins[i];
      #1;
      checks++;
      if (sbox_out !== exps[i]) begin
        errors++;
        $display("FAIL inv_sbox_%h got=%h exp=%h", ins[i], sbox_out, exps[i]);
      end
    end
  endtask

  task automatic test_inv_sbox_roundtrip();
    for (int x = 0; x < 256; x++) begin
      sbox_in = fwd_tbl[x];
      #1;
      checks++;
      if (sbox_out !== 8'(x)) begin
        errors++;
        $display("FAIL inv_sbox_rt in=%h got=%h exp=%h", fwd_tbl[x], sbox_out, 8'(x));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips_key();
    test_zero_key();
    test_restart();
    test_kld_held();
    test_inv_sbox_spot();
    test_inv_sbox_roundtrip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
